// File: rtl/bk_add_seq_ctrl.sv
// bk_add_seq_ctrl
// Sequential wrapper around a 12-bit combinational Brent-Kung adder. Operand
// pairs arrive over a valid/ready handshake and are registered. The adder is
// driven with an interleaved operand vector. After SETTLE_CYCLES cycles the
// 13-bit sum is captured and offered downstream over a second valid/ready
// handshake. Accumulate mode reuses the previous sum as operand A and keeps
// a sticky overflow flag across the chain.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operand pair valid
//   in_ready_o   block can accept an operand pair
//   in_a_i       operand A (ignored when in_acc_i = 1)
//   in_b_i       operand B
//   in_acc_i     1 = use previous out_sum[11:0] as operand A
//   adder_in_o   interleaved operands: [2i] = A[i], [2i+1] = B[i]
//   adder_out_i  adder sum, bit 12 is carry-out
//   out_valid_o  result valid
//   out_ready_i  downstream accepts result
//   out_sum_o    captured sum
//   out_ovf_o    sticky overflow across an accumulate chain

module bk_add_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [11:0] in_a_i,
    input  logic [11:0] in_b_i,
    input  logic        in_acc_i,
    output logic [23:0] adder_in_o,
    input  logic [12:0] adder_out_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [12:0] out_sum_o,
    output logic        out_ovf_o
);

    typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

    localparam logic [3:0] CntLoad = 4'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [11:0] opa_q, opa_d;
    logic [11:0] opb_q, opb_d;
    logic [12:0] sum_q, sum_d;
    logic        ovf_q, ovf_d;
    logic        acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        in_rdy;
    logic        accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_rdy      = 1'b0;
        out_valid_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_rdy = 1'b1;
            end
            StSettle: begin
                if (cnt_q == 4'd0) begin
                    sum_d   = adder_out_i;
                    // A fresh (non-accumulate) transaction restarts the chain.
                    ovf_d   = (acc_q & ovf_q) | adder_out_i[12];
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                out_valid_o = 1'b1;
                // Pop and push in the same cycle keeps the stream bubble-free.
                in_rdy      = out_ready_i;
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        accept = in_valid_i & in_rdy;
        if (accept) begin
            opa_d   = in_acc_i ? sum_q[11:0] : in_a_i;
            opb_d   = in_b_i;
            acc_d   = in_acc_i;
            cnt_d   = CntLoad;
            state_d = StSettle;
        end
    end

    always_comb begin
        adder_in_o = '0;
        for (int i = 0; i < 12; i++) begin
            adder_in_o[2*i]   = opa_q[i];
            adder_in_o[2*i+1] = opb_q[i];
        end
    end

    assign in_ready_o = in_rdy;
    assign out_sum_o  = sum_q;
    assign out_ovf_o  = ovf_q;

endmodule
